// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master: FSM states, slave decode codes, timeout counter width.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ERR    = 2'd3
  } state_e;

  localparam logic [1:0] SLV1 = 2'b00;
  localparam logic [1:0] SLV2 = 2'b01;

  localparam int TO_CNT_W = 8;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational slave decode from the top two address bits (addr[7:6]).
module apb_addr_decode
  import apb_pkg::*;
(
  input  logic [1:0] region_i,
  output logic       sel1_o,
  output logic       sel2_o,
  output logic       unmapped_o
);

  assign sel1_o     = (region_i == SLV1);
  assign sel2_o     = (region_i == SLV2);
  assign unmapped_o = region_i[1];

endmodule

// File: rtl/apb_master.sv
// Two-slave APB master with back-to-back transfers and error completion for unmapped addresses.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYCLES.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic [DATA_W-1:0] PRDATA2,
  input  logic              PREADY1,
  input  logic              PREADY2
);

  // Decode uses addr[7:6], and the timeout limit must fit the counter.
  if (ADDR_W < 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TO_CNT_W)) begin : g_param_check
    $error("apb_master: ADDR_W must be >= 8 and TIMEOUT_CYCLES must fit in TO_CNT_W bits");
  end

  state_e            state_q;
  logic              psel1_q, psel2_q, penable_q, pwrite_q;
  logic              done_q, err_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q, rdata_q;

  logic              sel1, sel2, unmapped;
  logic              sel_pready, accept;
  logic [DATA_W-1:0] sel_prdata;

`ifdef APB_MASTER_TIMEOUT_EN
  logic [TO_CNT_W-1:0] cnt_q;
`endif

  apb_addr_decode u_decode (
    .region_i  (addr[7:6]),
    .sel1_o    (sel1),
    .sel2_o    (sel2),
    .unmapped_o(unmapped)
  );

  // Only the selected slave's handshake matters; the other one is ignored.
  assign sel_pready = psel1_q ? PREADY1 : PREADY2;
  assign sel_prdata = psel1_q ? PRDATA1 : PRDATA2;

  assign ready  = (state_q == IDLE) || ((state_q == ACCESS) && sel_pready);
  assign accept = req && ready;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      psel1_q   <= 1'b0;
      psel2_q   <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: ;
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (sel_pready) begin
            done_q    <= 1'b1;
            if (!pwrite_q) rdata_q <= sel_prdata;
            psel1_q   <= 1'b0;
            psel2_q   <= 1'b0;
            penable_q <= 1'b0;
            state_q   <= IDLE;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1)) begin
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            psel1_q   <= 1'b0;
            psel2_q   <= 1'b0;
            penable_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        ERR: begin
          done_q  <= 1'b1;
          err_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // An accepted request overrides the IDLE return above, giving back-to-back transfers.
      if (accept) begin
        pwrite_q  <= wr;
        paddr_q   <= addr;
        pwdata_q  <= wdata;
        psel1_q   <= sel1;
        psel2_q   <= sel2;
        penable_q <= 1'b0;
        state_q   <= unmapped ? ERR : SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_q     <= '0;
`endif
      end
    end
  end

  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign PSEL1   = psel1_q;
  assign PSEL2   = psel2_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;

endmodule
